// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: default width, ALU op codes and FSM states.
package alu_sequencer_pkg;

    localparam int N_DEF = 4;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOTA = 3'b101;
    localparam logic [2:0] OP_NOTB = 3'b110;
    localparam logic [2:0] OP_ZERO = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, result and debug-read bundle between a host controller (master) and the sequencer (slave).
interface alu_sequencer_if #(parameter int N = 4);

    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_load;
    logic [2:0]   cmd_op;
    logic [1:0]   cmd_dst;
    logic [1:0]   cmd_src_a;
    logic [1:0]   cmd_src_b;
    logic [N-1:0] cmd_imm;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic [1:0]   res_dst;
    logic         res_zero;
    logic [1:0]   dbg_idx;
    logic [N-1:0] dbg_data;

    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        output res_ready, dbg_idx,
        input  cmd_ready, res_valid, res_data, res_dst, res_zero, dbg_data
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        input  res_ready, dbg_idx,
        output cmd_ready, res_valid, res_data, res_dst, res_zero, dbg_data
    );

endinterface

// File: rtl/alu_sequencer_alu_core.sv
// Purely combinational 3-bit-opcode ALU; add/sub wrap modulo 2^N with carry/borrow dropped.
module alu_core
    import alu_sequencer_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [2:0]   s_i,
    output logic [N-1:0] f_o
);

    always_comb begin
        f_o = '0;
        case (s_i)
            OP_AND:  f_o = a_i & b_i;
            OP_OR:   f_o = a_i | b_i;
            OP_ADD:  f_o = a_i + b_i;
            OP_SUB:  f_o = a_i - b_i;
            OP_XOR:  f_o = a_i ^ b_i;
            OP_NOTA: f_o = ~a_i;
            OP_NOTB: f_o = ~b_i;
            OP_ZERO: f_o = '0;
            default: f_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven front end for the ALU: 4-entry register file, IDLE/EXEC/RESP sequencing,
// result returned over a valid/ready port that holds steady until consumed.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);

    state_e       state_q, state_d;
    logic         ready_q, ready_d;
    logic [2:0]   op_q;
    logic [1:0]   dst_q, src_a_q, src_b_q;
    logic [N-1:0] rf_q [4];
    logic [N-1:0] res_data_q;
    logic [1:0]   res_dst_q;

    logic         accept;
    logic         wr_en;
    logic [1:0]   wr_idx;
    logic [N-1:0] wr_data;
    logic [N-1:0] alu_f;

    assign accept = bus.cmd_valid & ready_q;

    alu_core #(.N(N)) u_alu_core (
        .a_i (rf_q[src_a_q]),
        .b_i (rf_q[src_b_q]),
        .s_i (op_q),
        .f_o (alu_f)
    );

    // ready is its own flop so it stays low for every cycle rst_n is held low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = bus.cmd_load ? ST_RESP : ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_comb begin
        bus.cmd_ready = ready_q;
        bus.res_valid = (state_q == ST_RESP);
        bus.res_data  = res_data_q;
        bus.res_dst   = res_dst_q;
        bus.res_zero  = (res_data_q == '0);
        bus.dbg_data  = rf_q[bus.dbg_idx];
    end

    // One write port: loads write at the accept edge, ALU ops at the end of EXEC
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = dst_q;
        wr_data = alu_f;
        if (state_q == ST_EXEC) begin
            wr_en = 1'b1;
        end else if (accept && bus.cmd_load) begin
            wr_en   = 1'b1;
            wr_idx  = bus.cmd_dst;
            wr_data = bus.cmd_imm;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rf
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rf_q[gi] <= '0;
                end else if (wr_en && (wr_idx == 2'(gi))) begin
                    rf_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= OP_AND;
            dst_q      <= '0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            res_data_q <= '0;
            res_dst_q  <= '0;
        end else begin
            if (accept) begin
                op_q    <= bus.cmd_op;
                dst_q   <= bus.cmd_dst;
                src_a_q <= bus.cmd_src_a;
                src_b_q <= bus.cmd_src_b;
            end
            if (wr_en) begin
                res_data_q <= wr_data;
                res_dst_q  <= wr_idx;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: table of load/ALU commands plus stall and mid-EXEC reset sequences.
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.N(4)) bus ();

    alu_sequencer #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       load;
        logic [2:0] op;
        logic [1:0] dst;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] imm;
        logic [3:0] exp_data;
        logic       exp_zero;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic load, input logic [2:0] op, input logic [1:0] dst,
                                input logic [1:0] a, input logic [1:0] b, input logic [3:0] imm,
                                input logic [3:0] exp_data);
        vec_t v;
        v.load = load; v.op = op; v.dst = dst; v.a = a; v.b = b; v.imm = imm;
        v.exp_data = exp_data;
        v.exp_zero = (exp_data == 4'h0);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.cmd_ready && n < 20) begin tick(); n++; end
        check({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic drive(input vec_t v);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = v.load;
        bus.cmd_op    = v.op;
        bus.cmd_dst   = v.dst;
        bus.cmd_src_a = v.a;
        bus.cmd_src_b = v.b;
        bus.cmd_imm   = v.imm;
    endtask

    task automatic check_regs(input string tag, input logic [3:0] r0, input logic [3:0] r1,
                              input logic [3:0] r2, input logic [3:0] r3);
        logic [3:0] exp [4];
        exp[0] = r0; exp[1] = r1; exp[2] = r2; exp[3] = r3;
        for (int i = 0; i < 4; i++) begin
            bus.dbg_idx = 2'(i);
            #1;
            check($sformatf("%s dbg r%0d", tag, i), 32'(bus.dbg_data), 32'(exp[i]));
        end
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        int lat;
        string tag;
        tag = $sformatf("vec%0d", idx);
        wait_ready(tag);
        drive(v);
        tick();
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.res_valid && lat < 20) begin tick(); lat++; end
        check({tag, " latency"}, 32'(lat), v.load ? 32'd1 : 32'd2);
        check({tag, " res_data"}, 32'(bus.res_data), 32'(v.exp_data));
        check({tag, " res_dst"}, 32'(bus.res_dst), 32'(v.dst));
        check({tag, " res_zero"}, 32'(bus.res_zero), 32'(v.exp_zero));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({tag, " res_valid drop"}, 32'(bus.res_valid), 32'd0);
        check({tag, " ready again"}, 32'(bus.cmd_ready), 32'd1);
        bus.dbg_idx = v.dst;
        #1;
        check({tag, " dbg dst"}, 32'(bus.dbg_data), 32'(v.exp_data));
        $display("cmd %0d load=%0b op=%0d dst=%0d a=%0d b=%0d imm=%0h -> data=%0h lat=%0d",
                 idx, v.load, v.op, v.dst, v.a, v.b, v.imm, v.exp_data, lat);
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_load = 1'b0; bus.cmd_op = 3'd0;
        bus.cmd_dst = 2'd0; bus.cmd_src_a = 2'd0; bus.cmd_src_b = 2'd0; bus.cmd_imm = 4'h0;
        bus.res_ready = 1'b0; bus.dbg_idx = 2'd0;

        //                load op     dst    a      b      imm    expected
        vecs[0]  = mk(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h9, 4'h9);
        vecs[1]  = mk(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'h3, 4'h3);
        vecs[2]  = mk(1'b0, 3'd2, 2'd2, 2'd0, 2'd1, 4'h0, 4'hC);  // 9+3
        vecs[3]  = mk(1'b0, 3'd3, 2'd3, 2'd1, 2'd0, 4'h0, 4'hA);  // 3-9 wraps
        vecs[4]  = mk(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 4'h0, 4'h1);  // 9&3
        vecs[5]  = mk(1'b0, 3'd1, 2'd3, 2'd0, 2'd1, 4'h0, 4'hB);  // 9|3
        vecs[6]  = mk(1'b0, 3'd4, 2'd2, 2'd0, 2'd3, 4'h0, 4'h2);  // 9^B
        vecs[7]  = mk(1'b0, 3'd5, 2'd3, 2'd1, 2'd0, 4'h0, 4'hC);  // ~3
        vecs[8]  = mk(1'b0, 3'd6, 2'd2, 2'd0, 2'd1, 4'h0, 4'hC);  // ~3 via b
        vecs[9]  = mk(1'b0, 3'd2, 2'd0, 2'd0, 2'd0, 4'h0, 4'h2);  // r0=r0+r0, 9+9
        vecs[10] = mk(1'b0, 3'd7, 2'd1, 2'd0, 2'd0, 4'h0, 4'h0);
        vecs[11] = mk(1'b0, 3'd3, 2'd2, 2'd1, 2'd0, 4'h0, 4'hE);  // 0-2
        vecs[12] = mk(1'b0, 3'd2, 2'd3, 2'd2, 2'd2, 4'h0, 4'hC);  // E+E
        vecs[13] = mk(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0);

        // Reset held for two edges
        tick(); tick();
        check("rst res_valid", 32'(bus.res_valid), 32'd0);
        check("rst res_data", 32'(bus.res_data), 32'd0);
        check("rst res_dst", 32'(bus.res_dst), 32'd0);
        check("rst res_zero", 32'(bus.res_zero), 32'd1);
        check("rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_regs("rst", 4'h0, 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;
        check("pre-release cmd_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        check("release cmd_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 14; i++) run_cmd(vecs[i], i);
        check_regs("table end", 4'h0, 4'h0, 4'hE, 4'hC);

        // Result stalled by consumer while another command is offered
        begin
            vec_t v;
            int n = 0;
            wait_ready("stall");
            drive(mk(1'b0, 3'd2, 2'd1, 2'd2, 2'd3, 4'h0, 4'hA));
            tick();
            drive(mk(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'hF, 4'hF));
            while (!bus.res_valid && n < 20) begin tick(); n++; end
            check("stall latency", 32'(n), 32'd1);
            for (int c = 0; c < 5; c++) begin
                check($sformatf("stall%0d res_valid", c), 32'(bus.res_valid), 32'd1);
                check($sformatf("stall%0d res_data", c), 32'(bus.res_data), 32'hA);
                check($sformatf("stall%0d res_dst", c), 32'(bus.res_dst), 32'd1);
                check($sformatf("stall%0d cmd_ready", c), 32'(bus.cmd_ready), 32'd0);
                tick();
            end
            bus.cmd_valid = 1'b0;
            bus.res_ready = 1'b1;
            tick();
            bus.res_ready = 1'b0;
            check("stall res_valid drop", 32'(bus.res_valid), 32'd0);
            check_regs("stall", 4'h0, 4'hA, 4'hE, 4'hC);
            $display("stall: ADD r1=r2+r3 -> A held 5 cycles, offered load not accepted");
        end

        // Reset asserted while an ADD is in EXEC
        wait_ready("abort");
        drive(mk(1'b0, 3'd2, 2'd0, 2'd2, 2'd3, 4'h0, 4'hA));
        tick();
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        check("abort in exec res_valid", 32'(bus.res_valid), 32'd0);
        tick();
        check("abort res_valid", 32'(bus.res_valid), 32'd0);
        check("abort res_data", 32'(bus.res_data), 32'd0);
        check("abort res_zero", 32'(bus.res_zero), 32'd1);
        check("abort cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_regs("abort", 4'h0, 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;
        tick();
        check("abort release cmd_ready", 32'(bus.cmd_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("abort quiet%0d res_valid", c), 32'(bus.res_valid), 32'd0);
            tick();
        end
        $display("abort: reset during EXEC discarded ADD, regfile cleared");
        run_cmd(mk(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 4'h5, 4'h5), 14);
        check_regs("post abort", 4'h0, 4'h0, 4'h0, 4'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
